// File: rtl/gtrg_dav_fifo_if.sv
// gtrg_dav_fifo_if: groups the trigger, readout and status signals of gtrg_dav_fifo.
// Latency: none, wires only.
// Backpressure: none here; FULL/AFULL/EMPTY_B carry the FIFO state to the producer and consumer.
// master = trigger/readout side (drives PUSH, POP, config), slave = the FIFO block.
interface gtrg_dav_fifo_if #(
  parameter int NCH = 5,
  parameter int AW  = 10,
  parameter int BXW = 12
);
  // requests and configuration
  logic           PUSH;
  logic           POP;
  logic           BC0;
  logic [NCH-1:0] DAV;
  logic [NCH-1:0] KILLMASK;
  logic [4:0]     PUSHDLY;
  logic [2:0]     DAVWIN;
  logic [AW:0]    AFULL_THR;
  logic           ERRCLR;
  // status and readout
  logic           DPUSH;
  logic           EMPTY_B;
  logic           FULL;
  logic           AFULL;
  logic [AW:0]    LEVEL;
  logic [NCH-1:0] DOUT_DAV;
  logic [BXW-1:0] DOUT_BX;
  logic           DOUT_VALID;
  logic [7:0]     OVFCNT;
  logic           ERR;

  modport master (
    output PUSH, POP, BC0, DAV, KILLMASK, PUSHDLY, DAVWIN, AFULL_THR, ERRCLR,
    input  DPUSH, EMPTY_B, FULL, AFULL, LEVEL, DOUT_DAV, DOUT_BX, DOUT_VALID, OVFCNT, ERR
  );

  modport slave (
    input  PUSH, POP, BC0, DAV, KILLMASK, PUSHDLY, DAVWIN, AFULL_THR, ERRCLR,
    output DPUSH, EMPTY_B, FULL, AFULL, LEVEL, DOUT_DAV, DOUT_BX, DOUT_VALID, OVFCNT, ERR
  );
endinterface

// File: rtl/gtrg_dav_fifo.sv
// gtrg_dav_fifo: records {windowed DAV OR, BX at L1A} per delayed push into a 2^AW FIFO.
// Latency: PUSH->DPUSH/write PUSHDLY+1 cycles; POP->DOUT_VALID 1 cycle; one write + one read per cycle.
// Backpressure: none on push; a DPUSH while FULL is dropped, counted in OVFCNT and flagged in ERR.
// Ports: CLK, RST_B (async active-low) plus bus (slave modport): PUSH/POP/BC0/DAV/KILLMASK and
// config PUSHDLY/DAVWIN/AFULL_THR/ERRCLR in; DPUSH, EMPTY_B/FULL/AFULL/LEVEL, DOUT_*, OVFCNT, ERR out.
module gtrg_dav_fifo #(
  parameter int NCH    = 5,
  parameter int AW     = 10,
  parameter int BXW    = 12,
  parameter int BX_MAX = 3563
) (
  input  logic           CLK,
  input  logic           RST_B,
  gtrg_dav_fifo_if.slave bus
);
  localparam int DEPTH  = 1 << AW;
  localparam int DLY_N  = 32;
  localparam int HIST_N = 8;

  typedef struct packed {
    logic           push;
    logic [BXW-1:0] bx;
  } dly_t;

  typedef struct packed {
    logic [NCH-1:0] dav;
    logic [BXW-1:0] bx;
  } rec_t;

  // ---------------- BX counter ----------------
  logic [BXW-1:0] bx_cnt;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B)                        bx_cnt <= '0;
    else if (bus.BC0)                  bx_cnt <= '0;
    else if (bx_cnt == BXW'(BX_MAX))   bx_cnt <= '0;
    else                               bx_cnt <= bx_cnt + 1'b1;
  end

  // ---------------- DAV window ----------------
  logic [NCH-1:0] dav_s;
  logic [NCH-1:0] dav_hist [1:HIST_N-1];  // dav_hist[i] = dav_s from i cycles ago
  logic [NCH-1:0] dav_win;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      dav_s <= '0;
      for (int i = 1; i < HIST_N; i++) dav_hist[i] <= '0;
    end else begin
      dav_s       <= bus.DAV & ~bus.KILLMASK;
      dav_hist[1] <= dav_s;
      for (int i = 2; i < HIST_N; i++) dav_hist[i] <= dav_hist[i-1];
    end
  end

  always_comb begin
    dav_win = dav_s;
    for (int i = 1; i < HIST_N; i++)
      if (bus.DAVWIN >= 3'(i)) dav_win = dav_win | dav_hist[i];
  end

  // ---------------- push delay line ----------------
  dly_t dly [DLY_N];
  dly_t dly_tap;

  assign dly_tap = dly[bus.PUSHDLY];

  // A push bit is dropped once it passes the active tap, so raising PUSHDLY
  // afterwards can never deliver the same L1A a second time.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int i = 0; i < DLY_N; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {bus.PUSH, bx_cnt};
      for (int i = 1; i < DLY_N; i++) begin
        dly[i].bx   <= dly[i-1].bx;
        dly[i].push <= dly[i-1].push && (bus.PUSHDLY != 5'(i-1));
      end
    end
  end

  // ---------------- FIFO storage and pointers ----------------
  rec_t           mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [AW:0]    level;
  logic           full;
  logic           empty_b;
  logic           wr;
  logic           rd;
  logic           ovf;
  logic           udf;
  logic [NCH-1:0] dout_dav;
  logic [BXW-1:0] dout_bx;
  logic           dout_valid;
  logic [7:0]     ovfcnt;
  logic           err;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty_b = (level != '0);
  assign wr      = dly_tap.push & ~full;
  assign rd      = bus.POP & empty_b;
  assign ovf     = dly_tap.push & full;
  assign udf     = bus.POP & ~empty_b;

  // RAM contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (wr) mem[wptr] <= {dav_win, dly_tap.bx};
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      dout_dav   <= '0;
      dout_bx    <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rptr     <= rptr + 1'b1;
        dout_dav <= mem[rptr].dav;
        dout_bx  <= mem[rptr].bx;
      end
      dout_valid <= rd;
      // simultaneous write and read leaves the level unchanged
      level <= level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
    end
  end

  // ---------------- error reporting ----------------
  // A fresh error in the ERRCLR cycle wins over the clear.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      err    <= 1'b0;
      ovfcnt <= '0;
    end else begin
      if (ovf || udf)      err <= 1'b1;
      else if (bus.ERRCLR) err <= 1'b0;

      if (bus.ERRCLR)                 ovfcnt <= {7'd0, ovf};
      else if (ovf && ovfcnt != 8'hFF) ovfcnt <= ovfcnt + 1'b1;
    end
  end

  // ---------------- outputs ----------------
  assign bus.DPUSH      = dly_tap.push;
  assign bus.EMPTY_B    = empty_b;
  assign bus.FULL       = full;
  assign bus.AFULL      = (level >= bus.AFULL_THR);
  assign bus.LEVEL      = level;
  assign bus.DOUT_DAV   = dout_dav;
  assign bus.DOUT_BX    = dout_bx;
  assign bus.DOUT_VALID = dout_valid;
  assign bus.OVFCNT     = ovfcnt;
  assign bus.ERR        = err;
endmodule

// File: tb/tb_gtrg_dav_fifo.sv
// tb_gtrg_dav_fifo: scenario tasks plus randomized traffic against a queue-based reference model.
// Latency: inputs change #1 after the rising edge, outputs are sampled on the falling edge.
// Backpressure: the model drops pushes when its queue holds DEPTH records.
module tb_gtrg_dav_fifo;
  localparam int NCH    = 5;
  localparam int AW     = 4;
  localparam int BXW    = 12;
  localparam int BX_MAX = 3563;
  localparam int DEPTH  = 1 << AW;
  localparam int VW     = 4 + (AW + 1) + 1 + NCH + BXW + 8 + 1;

  logic CLK;
  logic RST_B;

  gtrg_dav_fifo_if #(.NCH(NCH), .AW(AW), .BXW(BXW)) bus ();

  gtrg_dav_fifo #(.NCH(NCH), .AW(AW), .BXW(BXW), .BX_MAX(BX_MAX)) dut (
    .CLK  (CLK),
    .RST_B(RST_B),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct { int due; int bx; } pend_t;
  typedef struct packed { logic [NCH-1:0] dav; logic [BXW-1:0] bx; } rec_t;

  pend_t          pend_q[$];
  rec_t           fifo_q[$];
  logic [NCH-1:0] hist [64];      // masked DAV input seen in each model cycle
  int             cyc;
  int             bx_m;
  logic           m_valid;
  logic [NCH-1:0] m_dout_dav;
  logic [BXW-1:0] m_dout_bx;
  int             m_ovf;
  logic           m_err;

  logic [VW-1:0]  obs;
  logic [VW-1:0]  exp_v;
  int             checks;
  int             passes;

  function automatic logic [VW-1:0] sample();
    return {bus.DPUSH, bus.EMPTY_B, bus.FULL, bus.AFULL, bus.LEVEL, bus.DOUT_VALID,
            bus.DOUT_DAV, bus.DOUT_BX, bus.OVFCNT, bus.ERR};
  endfunction

  task automatic reset_model();
    pend_q.delete();
    fifo_q.delete();
    for (int i = 0; i < 64; i++) hist[i] = '0;
    bx_m       = 0;
    m_valid    = 1'b0;
    m_dout_dav = '0;
    m_dout_bx  = '0;
    m_ovf      = 0;
    m_err      = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.PUSH   = 1'b0;
    bus.POP    = 1'b0;
    bus.BC0    = 1'b0;
    bus.ERRCLR = 1'b0;
    bus.DAV    = '0;
  endtask

  // One clock cycle: predict this cycle's outputs, sample the DUT, then advance the model.
  task automatic tick();
    logic [NCH-1:0] win;
    logic dp, full, wr, rd, ovf, udf;
    int dbx;
    win = '0;
    for (int k = 0; k <= int'(bus.DAVWIN); k++) win |= hist[(cyc - 1 - k) & 63];
    dp   = (pend_q.size() > 0) && (pend_q[0].due == cyc);
    dbx  = dp ? pend_q[0].bx : 0;
    full = (fifo_q.size() == DEPTH);
    exp_v = {dp, fifo_q.size() != 0, full, fifo_q.size() >= int'(bus.AFULL_THR),
             (AW+1)'(fifo_q.size()), m_valid, m_dout_dav, m_dout_bx, 8'(m_ovf), m_err};
    @(negedge CLK);
    obs = sample();
    @(posedge CLK);
    #1;
    wr  = dp && !full;
    ovf = dp && full;
    rd  = bus.POP && (fifo_q.size() != 0);
    udf = bus.POP && (fifo_q.size() == 0);
    if (dp) void'(pend_q.pop_front());
    m_valid = rd;
    if (rd) begin
      m_dout_dav = fifo_q[0].dav;
      m_dout_bx  = fifo_q[0].bx;
      void'(fifo_q.pop_front());
    end
    if (wr) fifo_q.push_back({win, BXW'(dbx)});
    if (ovf || udf) m_err = 1'b1;
    else if (bus.ERRCLR) m_err = 1'b0;
    if (bus.ERRCLR) m_ovf = ovf ? 1 : 0;
    else if (ovf && m_ovf < 255) m_ovf++;
    if (bus.PUSH) pend_q.push_back('{cyc + int'(bus.PUSHDLY) + 1, bx_m});
    if (bus.BC0) bx_m = 0;
    else if (bx_m == BX_MAX) bx_m = 0;
    else bx_m++;
    hist[cyc & 63] = bus.DAV & ~bus.KILLMASK;
    cyc++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST_B = 1'b0;
    clear_inputs();
    bus.KILLMASK = '0; bus.PUSHDLY = '0; bus.DAVWIN = '0; bus.AFULL_THR = 5'd12;
    reset_model();
    #12;
    checks++;
    if (sample() !== '0) $display("FAIL reset_outputs obs=%h exp=0", sample());
    else passes++;
    bus.AFULL_THR = '0;
    #1;
    checks++;
    if (bus.AFULL !== 1'b1) $display("FAIL reset_afull_thr0 obs=%b exp=1", bus.AFULL);
    else passes++;
    bus.AFULL_THR = 5'd12;
    @(posedge CLK); #1;
    RST_B = 1'b1;
  endtask

  task automatic test_basic();
    clear_inputs(); bus.PUSHDLY = 5'd4; bus.DAVWIN = '0;
    for (int i = 0; i < 4000 && bx_m != 100; i++) begin
      tick(); checks++;
      if (obs !== exp_v) $display("FAIL basic cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    bus.PUSH = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); bus.PUSH = 1'b0; checks++;
      if (obs !== exp_v) $display("FAIL basic cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    checks++;
    if (bus.LEVEL !== 5'd1 || bus.EMPTY_B !== 1'b1)
      $display("FAIL basic_write level=%0d empty_b=%b exp 1/1", bus.LEVEL, bus.EMPTY_B);
    else passes++;
    bus.POP = 1'b1;
    tick(); bus.POP = 1'b0; checks++;
    if (obs !== exp_v) $display("FAIL basic cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    checks++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT_BX !== 12'd100 || bus.LEVEL !== 5'd0)
      $display("FAIL basic_pop valid=%b bx=%0d level=%0d exp 1/100/0", bus.DOUT_VALID, bus.DOUT_BX, bus.LEVEL);
    else passes++;
    tick(); checks++;
    if (obs !== exp_v) $display("FAIL basic cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
  endtask

  task automatic test_dav_window();
    logic [NCH-1:0] want [2];
    want[0] = 5'b00100;
    want[1] = 5'b00000;
    bus.PUSHDLY = '0; bus.DAVWIN = 3'd3;
    for (int r = 0; r < 2; r++) begin
      bus.KILLMASK = (r == 1) ? 5'b00100 : 5'b00000;
      repeat (9) begin
        tick(); checks++;
        if (obs !== exp_v) $display("FAIL dav_win cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
      end
      // cycle D: DAV pulse, D+2: PUSH, D+3: DPUSH, D+4: POP
      for (int s = 0; s < 6; s++) begin
        bus.DAV  = (s == 0) ? 5'b00100 : 5'b00000;
        bus.PUSH = (s == 2);
        bus.POP  = (s == 4);
        tick(); checks++;
        if (obs !== exp_v) $display("FAIL dav_win cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
      end
      clear_inputs();
      checks++;
      if (bus.DOUT_DAV !== want[r])
        $display("FAIL dav_win_pattern kill=%b obs=%b exp=%b", bus.KILLMASK, bus.DOUT_DAV, want[r]);
      else passes++;
    end
    bus.KILLMASK = '0;
  endtask

  task automatic test_pop_empty();
    clear_inputs(); bus.PUSHDLY = '0;
    bus.ERRCLR = 1'b1;
    tick(); bus.ERRCLR = 1'b0;
    bus.POP = 1'b1;
    tick(); bus.POP = 1'b0;
    checks++;
    if (obs !== exp_v) $display("FAIL pop_empty cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    checks++;
    if (bus.ERR !== 1'b1 || bus.LEVEL !== 5'd0 || bus.DOUT_VALID !== 1'b0)
      $display("FAIL pop_empty err=%b level=%0d valid=%b exp 1/0/0", bus.ERR, bus.LEVEL, bus.DOUT_VALID);
    else passes++;
    // DPUSH coinciding with a pop on an empty FIFO is still written
    bus.PUSH = 1'b1;
    tick(); bus.PUSH = 1'b0; bus.POP = 1'b1;
    tick(); checks++;
    if (obs !== exp_v) $display("FAIL pop_empty_wr cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    checks++;
    if (bus.LEVEL !== 5'd1) $display("FAIL pop_empty_wr level=%0d exp 1", bus.LEVEL); else passes++;
    tick(); bus.POP = 1'b0; checks++;
    if (obs !== exp_v) $display("FAIL pop_empty_wr cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
  endtask

  task automatic test_full_overflow();
    clear_inputs(); bus.PUSHDLY = '0; bus.AFULL_THR = 5'd12;
    bus.ERRCLR = 1'b1;
    tick(); bus.ERRCLR = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.PUSH = (i < 16);
      bus.DAV  = NCH'($urandom);
      tick(); checks++;
      if (obs !== exp_v) $display("FAIL full cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    bus.DAV = '0;
    checks++;
    if (bus.FULL !== 1'b1 || bus.AFULL !== 1'b1 || bus.LEVEL !== 5'd16)
      $display("FAIL full_state full=%b afull=%b level=%0d exp 1/1/16", bus.FULL, bus.AFULL, bus.LEVEL);
    else passes++;
    bus.PUSH = 1'b1;
    tick(); bus.PUSH = 1'b0; bus.POP = 1'b1;
    tick(); bus.POP = 1'b0; checks++;
    if (obs !== exp_v) $display("FAIL full cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    checks++;
    if (bus.LEVEL !== 5'd15 || bus.OVFCNT !== 8'd1 || bus.ERR !== 1'b1)
      $display("FAIL overflow level=%0d ovfcnt=%0d err=%b exp 15/1/1", bus.LEVEL, bus.OVFCNT, bus.ERR);
    else passes++;
    bus.ERRCLR = 1'b1;
    tick(); bus.ERRCLR = 1'b0;
    checks++;
    if (bus.OVFCNT !== 8'd0 || bus.ERR !== 1'b0)
      $display("FAIL errclr ovfcnt=%0d err=%b exp 0/0", bus.OVFCNT, bus.ERR);
    else passes++;
    bus.POP = 1'b1;
    repeat (15) begin
      tick(); checks++;
      if (obs !== exp_v) $display("FAIL drain cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    bus.POP = 1'b0;
  endtask

  task automatic test_bx_wrap();
    logic [BXW-1:0] want [4];
    want[0] = 12'd2000; want[1] = 12'd0; want[2] = 12'd3563; want[3] = 12'd0;
    clear_inputs(); bus.PUSHDLY = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4000 && bx_m != ((r == 0) ? 2000 : BX_MAX); i++) begin
        tick(); checks++;
        if (obs !== exp_v) $display("FAIL bx_run cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
      end
      bus.BC0 = (r == 0); bus.PUSH = 1'b1;
      tick(); bus.BC0 = 1'b0;
      tick(); bus.PUSH = 1'b0;
      tick(); bus.POP = 1'b1;
      for (int j = 0; j < 2; j++) begin
        tick(); checks++;
        if (bus.DOUT_BX !== want[2*r+j] || bus.DOUT_VALID !== 1'b1)
          $display("FAIL bx_wrap rec=%0d bx=%0d valid=%b exp %0d/1", 2*r+j, bus.DOUT_BX, bus.DOUT_VALID, want[2*r+j]);
        else passes++;
      end
      bus.POP = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      automatic bit fill = ((i / 150) % 2) == 0;
      bus.PUSH   = $urandom_range(99) < (fill ? 65 : 30);
      bus.POP    = $urandom_range(99) < (fill ? 25 : 70);
      bus.DAV    = NCH'($urandom);
      bus.ERRCLR = ($urandom_range(29) == 0);
      bus.BC0    = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) bus.KILLMASK = NCH'($urandom);
      if ($urandom_range(9) == 0) bus.DAVWIN = 3'($urandom);
      if ($urandom_range(49) == 0) bus.AFULL_THR = 5'($urandom_range(17));
      if (pend_q.size() == 0 && $urandom_range(9) == 0) bus.PUSHDLY = 5'($urandom);
      tick(); checks++;
      if (obs !== exp_v) $display("FAIL random cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    clear_inputs(); bus.KILLMASK = '0; bus.AFULL_THR = 5'd12;
    bus.POP = 1'b1;
    repeat (DEPTH + 40) begin
      tick(); checks++;
      if (obs !== exp_v) $display("FAIL random_drain cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    bus.POP = 1'b0;
  endtask

  task automatic test_reset_midburst();
    clear_inputs(); bus.PUSHDLY = 5'd6; bus.DAVWIN = '0;
    bus.PUSH = 1'b1;
    for (int i = 0; i < 40 && fifo_q.size() != 7; i++) begin
      bus.DAV = NCH'($urandom);
      tick(); checks++;
      if (obs !== exp_v) $display("FAIL midburst cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    checks++;
    if (bus.LEVEL !== 5'd7 || pend_q.size() == 0)
      $display("FAIL midburst_setup level=%0d inflight=%0d exp 7/>0", bus.LEVEL, pend_q.size());
    else passes++;
    clear_inputs();
    RST_B = 1'b0;
    reset_model();
    #2;
    checks++;
    if (sample() !== '0) $display("FAIL midburst_reset obs=%h exp=0", sample()); else passes++;
    repeat (2) @(posedge CLK);
    #1;
    RST_B = 1'b1;
    repeat (10) begin
      tick(); checks++;
      if (obs !== exp_v) $display("FAIL post_reset cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    bus.PUSH = 1'b1;
    repeat (40) begin
      tick(); bus.PUSH = 1'b0; checks++;
      if (obs !== exp_v) $display("FAIL post_reset cyc=%0d obs=%h exp=%h", cyc, obs, exp_v); else passes++;
    end
    bus.POP = 1'b1;
    tick(); bus.POP = 1'b0;
    checks++;
    if (bus.DOUT_VALID !== 1'b1 || bus.DOUT_BX !== 12'd10 || bus.DOUT_DAV !== 5'd0 || bus.LEVEL !== 5'd0)
      $display("FAIL post_reset_rec valid=%b bx=%0d dav=%b level=%0d exp 1/10/0/0",
               bus.DOUT_VALID, bus.DOUT_BX, bus.DOUT_DAV, bus.LEVEL);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    cyc    = 100;
    test_reset();
    test_basic();
    test_dav_window();
    test_pop_empty();
    test_full_overflow();
    test_bx_wrap();
    test_random();
    test_reset_midburst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/gtrg_dav_fifo.md
# gtrg_dav_fifo

Parametrised global-trigger DAV FIFO, the successor to the fixed 5-CFEB GTRG FIFO in the DMB control path. For each delayed L1A push it records a time-windowed OR of NCH data-available lines, together with the BX count at the moment of the push, into a 2^AW-deep FIFO. The readout sequencer pops these records. The block adds a programmable DAV window, a per-channel kill mask, almost-full, a fill level, a saturating overflow counter and a sticky error flag.

## Interface
Parameters
- NCH, 5, number of DAV channels (1..16)
- AW, 10, FIFO address width; depth = 2^AW
- BXW, 12, BX counter width
- BX_MAX, 3563, last BX value before the counter wraps to 0

Ports
- CLK  in  1  system clock; all logic is on the rising edge
- RST_B  in  1  reset, asynchronous, active-low
- PUSH  in  1  L1A push request, one-cycle pulse
- POP  in  1  read request from the readout sequencer
- BC0  in  1  bunch-crossing-zero, synchronous BX counter reset
- DAV  in  NCH  raw DAV lines, already in the CLK domain
- KILLMASK  in  NCH  1 = force that channel to 0
- PUSHDLY  in  5  push delay, 0..31 cycles
- DAVWIN  in  3  DAV OR window length minus 1, giving 1..8 samples
- AFULL_THR  in  AW+1  almost-full threshold
- ERRCLR  in  1  clears ERR and OVFCNT
- DPUSH  out  1  delayed push strobe
- EMPTY_B  out  1  FIFO not empty
- FULL  out  1  LEVEL == 2^AW
- AFULL  out  1  LEVEL >= AFULL_THR
- LEVEL  out  AW+1  current occupancy
- DOUT_DAV  out  NCH  popped windowed DAV pattern
- DOUT_BX  out  BXW  popped BX count
- DOUT_VALID  out  1  DOUT_* updated this cycle
- OVFCNT  out  8  count of dropped pushes, saturating at 255
- ERR  out  1  sticky push-when-full / pop-when-empty flag

## Operation
- Reset: while RST_B=0, every output and internal register is 0, including the BX counter, the delay lines and the pointers. EMPTY_B=0, FULL=0. AFULL reflects 0 >= AFULL_THR. FIFO RAM contents are not reset.
- BX counter
  - Free-running.
  - Goes to 0 the cycle after BC0=1, or the cycle after the count equals BX_MAX.
  - BC0 has priority over the wrap.
- DAV path
  - dav_s is DAV & ~KILLMASK, registered once.
  - An 8-deep shift history of dav_s is kept.
  - dav_win is the per-channel OR of the newest DAVWIN+1 entries of that history, newest = the current dav_s.
- Push path
  - PUSH and the BX count are captured together into a delay line of BXW+1 bits.
  - DPUSH asserts PUSHDLY+1 cycles after PUSH.
  - The BX value carried with DPUSH is the BX count from the cycle PUSH was high.
- Write: wr = DPUSH & ~FULL. When wr is set, {dav_win, carried BX} is written at wptr in the DPUSH cycle, and wptr increments modulo 2^AW.
- Read: rd = POP & EMPTY_B. When rd is set, the entry at rptr is loaded into DOUT_* on the next edge, DOUT_VALID pulses for one cycle, and rptr increments. Between pops, DOUT_* hold their value.
- LEVEL
  - +1 on wr only, -1 on rd only, unchanged when both occur.
  - EMPTY_B = (LEVEL != 0).
- Boundary conditions
  - DPUSH while full: the push is dropped even if POP occurs in the same cycle. The pop still proceeds. OVFCNT increments and ERR sets.
  - POP while empty: ignored; ERR sets. A DPUSH in the same cycle is written normally.
  - ERRCLR clears ERR and OVFCNT on the next edge. A new error in the same cycle wins, giving ERR=1 and OVFCNT=1 if that error is an overflow.
  - Changes to PUSHDLY or DAVWIN take effect immediately. Pushes already in flight keep their captured BX; their delay is not guaranteed.

## Timing
- PUSH to DPUSH: PUSHDLY+1 cycles.
- DPUSH to write: same edge. LEVEL and EMPTY_B update on the edge ending the DPUSH cycle.
- Earliest pop after a write: the next cycle. POP to DOUT_VALID: 1 cycle.
- DAV edge to dav_win: 1 cycle. A DAV pulse appears in dav_win for DAVWIN+1 consecutive cycles.
- Full throughput: one write and one read per cycle, sustained.

## Test plan
- Reset, then PUSH at BX=100 with PUSHDLY=4 -> DPUSH at cycle +5. LEVEL=1, EMPTY_B=1. POP -> next cycle DOUT_BX=100, DOUT_VALID=1, LEVEL=0.
- DAV[2] pulse of 1 cycle, DAVWIN=3, DPUSH 2 cycles after dav_s -> DOUT_DAV=0b00100. Same with KILLMASK[2]=1 -> DOUT_DAV=0.
- AW=4: 16 pushes -> FULL=1; AFULL=1 once LEVEL>=AFULL_THR=12. 17th push plus simultaneous POP -> LEVEL=15, OVFCNT=1, ERR=1. ERRCLR -> both 0.
- POP when empty -> ERR=1, LEVEL stays 0, no DOUT_VALID.
- BC0 at BX=2000 -> BX=0 the next cycle. Free run -> BX goes from 3563 to 0. Records pushed across the wrap hold 3563 then 0.
- Assert RST_B=0 mid-burst with LEVEL=7 and pushes in flight -> all outputs 0, no DPUSH after release, next record read back equals the first post-reset push.
